// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter that lends one external up counter to two requesters for len-tick intervals.
// Optional RUN watchdog: define COUNTER_SHARE_ARBITER_TIMEOUT_EN to build it; otherwise err is tied low.
module counter_share_arbiter #(
   parameter int WIDTH      = 4,
   parameter int TMO_CYCLES = 2**WIDTH + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             cnt_clr,
   output logic             cnt_en,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             busy,
   output logic             err
);

   // state   | meaning
   // IDLE    | no owner, waiting for a request
   // CLEAR   | owner granted, counter cleared this cycle
   // RUN     | counter enabled until it reaches len_q
   // DONE    | one-cycle completion pulse to owner
   // RELEASE | grant held until owner drops req
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      DONE    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             rr_last_q, rr_last_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic             grant_sel;
   logic             req_own;
   logic             at_len;
   logic             tmo_hit;

   assign req_own = owner_q ? req1 : req0;
   assign at_len  = (cnt_q == len_q);

`ifdef COUNTER_SHARE_ARBITER_TIMEOUT_EN
   localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;

   // Down-counter loaded in CLEAR; terminal count on the TMO_CYCLES-th RUN cycle.
   always_comb begin
      tmo_d   = tmo_q;
      tmo_hit = 1'b0;
      if (state_q == CLEAR) begin
         tmo_d = TW'(TMO_CYCLES - 1);
      end else if (state_q == RUN) begin
         if (tmo_q == '0) tmo_hit = 1'b1;
         else             tmo_d   = tmo_q - 1'b1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (state_d == IDLE)
         err_d = 1'b0;
      else if (state_q == RUN && req_own && !at_len && tmo_hit)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      len_d     = len_q;
      grant_sel = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant_sel = (req0 && req1) ? ~rr_last_q : req1;
               owner_d   = grant_sel;
               rr_last_d = grant_sel;
               len_d     = grant_sel ? len1 : len0;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            state_d = req_own ? RUN : IDLE;
         end
         RUN: begin
            if (!req_own)
               state_d = IDLE;
            else if (at_len || tmo_hit)
               state_d = DONE;
         end
         DONE: begin
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!req_own) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         rr_last_q <= 1'b1;
         len_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         len_q     <= len_d;
      end
   end

   // cnt_en alone looks at live inputs so an abort or a reached count stops the counter at once.
   assign busy    = (state_q != IDLE);
   assign gnt0    = busy && !owner_q;
   assign gnt1    = busy &&  owner_q;
   assign done0   = (state_q == DONE) && !owner_q;
   assign done1   = (state_q == DONE) &&  owner_q;
   assign cnt_clr = (state_q == CLEAR);
   assign cnt_en  = (state_q == RUN) && req_own && !at_len;

endmodule

// File: doc/counter_share_arbiter.md
Name: counter_share_arbiter

Overview:
- Shares one external WIDTH-bit synchronous up counter between two requesters.
- Each requester asks for a counted interval of len ticks. The block arbitrates round-robin, clears the counter, enables it for exactly len cycles, then signals completion.
- Sits between client logic and the counter. It is the only driver of the counter's clear and enable.

Parameters:
- WIDTH, 4, width of counter value and of the len inputs.
- TMO_CYCLES, 2**WIDTH+2, RUN-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request; level; held until done0 or abort.
- len0  in  WIDTH  requester 0 tick count; sampled at grant.
- req1  in  1  requester 1 request.
- len1  in  WIDTH  requester 1 tick count.
- gnt0  out  1  requester 0 owns the counter.
- gnt1  out  1  requester 1 owns the counter.
- done0  out  1  one-cycle completion pulse, requester 0.
- done1  out  1  one-cycle completion pulse, requester 1.
- cnt_clr  out  1  synchronous clear to the counter, active-high.
- cnt_en  out  1  count enable to the counter.
- cnt_q  in  WIDTH  current counter value.
- busy  out  1  state != IDLE.
- err  out  1  timeout flag (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - gnt0, gnt1, done0, done1, cnt_clr, cnt_en, busy and err all read 0.
  - len_q clears to 0; owner clears to 0.
  - rr_last is set to 1, so requester 0 wins the first tie.
- State register: IDLE, CLEAR, RUN, DONE, RELEASE. All outputs are decoded from registered state, except cnt_en (see RUN).
- IDLE:
  - Neither req asserted: stay in IDLE.
  - Exactly one req asserted: grant it.
  - Both asserted: grant the requester != rr_last.
  - On grant: owner is registered, len_q is latched from that requester's len, rr_last is set to owner, next state is CLEAR.
  - Latency: req rising edge to gnt visible is 1 cycle.
- gnt(owner): 1 in CLEAR, RUN, DONE and RELEASE; 0 in IDLE.
- CLEAR:
  - cnt_clr=1 for exactly one cycle.
  - Next state is RUN.
- RUN:
  - cnt_en = (cnt_q != len_q), combinational.
  - When cnt_q == len_q, next state is DONE.
  - Net effect: the counter increments exactly len_q times; RUN lasts len_q+1 cycles.
  - len_q=0 gives one RUN cycle with cnt_en never asserted.
  - len_q=2**WIDTH-1 reaches all-ones with no wrap; the counter must not wrap under this controller.
- DONE:
  - done(owner)=1 for one cycle.
  - Next state is RELEASE.
- RELEASE:
  - gnt is held until req(owner)=0 (4-phase handshake).
  - Then next state is IDLE.
  - A new grant is possible the cycle after IDLE is reached; minimum back-to-back gap is 1 IDLE cycle.
- Abort: req(owner) dropping in CLEAR or RUN means:
  - next state is IDLE;
  - cnt_en=0 from the same cycle;
  - no done pulse;
  - rr_last is still updated.
- Stability: len changes after grant are ignored, because len_q is held.
- Non-owner: a non-owner's req is queued implicitly and served on the next IDLE with round-robin priority.
- Reset mid-operation: everything returns to reset values immediately. The counter is not cleared by this block until the next CLEAR.
- Exclusivity: gnt0 and gnt1 are never both 1; done0 and done1 are never both 1.

Optional Feature:
- Macro: COUNTER_SHARE_ARBITER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN.
  - If RUN persists TMO_CYCLES cycles (counter stuck or not responding), next state is DONE with err=1.
  - err stays 1 through DONE and RELEASE and clears on entry to IDLE.
  - The done pulse is still issued.
- Undefined:
  - No watchdog logic is built.
  - err is tied to 0.
  - RUN waits indefinitely.

Test Plan:
- Single request:
  - Stimulus: req0=1, len0=5; model counter attached.
  - Required: gnt0 one cycle later; cnt_clr pulses once; cnt_en high exactly 5 cycles; cnt_q ends at 5; done0 one pulse; gnt0 drops the cycle after req0 falls.
- Tie and round-robin:
  - Stimulus: from reset, req0=req1=1 simultaneously.
  - Required: gnt0 first; after release, gnt1 next. Repeat with both asserted again and gnt0 wins again (alternation holds).
- Zero length:
  - Stimulus: len1=0, req1=1.
  - Required: cnt_clr pulse; cnt_en never asserted; done1 in the second cycle after CLEAR.
- Full range:
  - Stimulus: len0=15, WIDTH=4.
  - Required: 15 enable cycles; cnt_q=15; no wrap to 0; done0 asserted.
- Abort and async reset:
  - Stimulus: drop req0 at cnt_q=3 with len0=10.
  - Required: next cycle IDLE; cnt_en=0; no done0; pending req1 granted.
  - Stimulus: separately, rst=0 mid-RUN.
  - Required: all outputs 0 without waiting for a clk edge.
- Timeout (macro defined):
  - Stimulus: hold cnt_q=0, len0=4.
  - Required: after TMO_CYCLES=18 RUN cycles, err=1 and done0 pulses. With the macro undefined, the FSM stays in RUN and err=0.
